// File: rtl/operand_packer_if.sv
// rtl/operand_packer_if.sv - handshake and lane bundle between operand source, packer and adder tree
//
// Purpose: groups the serial input stream, the flush strobe and the packed
// five-lane output bus of operand_packer into one interface.
// Signals:
//   IN_DATA/IN_VALID/IN_READY : serial operand stream into the packer
//   FLUSH                     : close the current partial group
//   A..E                      : packed operand lanes (1st..5th operand)
//   OUT_VALID/OUT_READY       : group handshake towards the adder tree
//   GROUP_CNT                 : real operands in the presented group (1..5)
//   PARTIAL                   : presented group was closed early by FLUSH
// Modports: master = stream source / group sink (testbench side),
//           slave  = the packer itself.
interface operand_packer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             FLUSH;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] E;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [2:0]       GROUP_CNT;
    logic             PARTIAL;

    modport master (
        output IN_DATA, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, A, B, C, D, E, OUT_VALID, GROUP_CNT, PARTIAL
    );

    modport slave (
        input  IN_DATA, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, A, B, C, D, E, OUT_VALID, GROUP_CNT, PARTIAL
    );
endinterface

// File: rtl/operand_packer.sv
// rtl/operand_packer.sv - packs a serial operand stream into five-lane groups for a ternary adder tree
//
// Purpose: collects up to five serial operands into a fill register, then
// moves the group into an output register that drives lanes A..E. A FLUSH
// closes a short group early with the unused lanes zeroed.
// Ports:
//   CLK   : single clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : operand_packer_if.slave (stream in, flush, packed group out)
module operand_packer #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    operand_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY      = 2'd0,
        S_FILLING    = 2'd1,
        S_STALL_FULL = 2'd2,
        S_FLUSH_PEND = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_fc;
    logic             r_alive;
    logic [WIDTH-1:0] r_fill [5];
    logic [WIDTH-1:0] r_out  [5];
    logic [2:0]       r_cnt;
    logic             r_part;
    logic             r_ovalid;

    state_t           w_state_nxt;
    logic [2:0]       w_fc_nxt;
    logic [WIDTH-1:0] w_fill_nxt [5];
    logic [WIDTH-1:0] w_out_nxt  [5];
    logic [2:0]       w_cnt_nxt;
    logic             w_part_nxt;
    logic             w_ovalid_nxt;

    logic             w_in_ready;
    logic             w_accept;
    logic [2:0]       w_fc_acc;
    logic             w_out_free;
    logic             w_full;
    logic             w_flush_close;
    logic             w_xfer;

    // r_alive holds IN_READY low through reset and releases it on the
    // first clock edge afterwards.
    assign w_in_ready    = r_alive && (r_fc < 3'd5) && (r_state != S_FLUSH_PEND);
    assign w_accept      = bus.IN_VALID && w_in_ready;
    // Fill count including a sample accepted this cycle.
    assign w_fc_acc      = r_fc + {2'b00, w_accept};
    assign w_out_free    = !r_ovalid || bus.OUT_READY;
    assign w_full        = (w_fc_acc == 3'd5);
    // A pending flush keeps asking to close; a new FLUSH only counts when
    // there is at least one operand to close.
    assign w_flush_close = (r_state == S_FLUSH_PEND) || (bus.FLUSH && (w_fc_acc != 3'd0));
    assign w_xfer        = (w_full || w_flush_close) && w_out_free;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_EMPTY;
            r_fc     <= 3'd0;
            r_alive  <= 1'b0;
            r_cnt    <= 3'd0;
            r_part   <= 1'b0;
            r_ovalid <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_fill[i] <= '0;
                r_out[i]  <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_fc     <= w_fc_nxt;
            r_alive  <= 1'b1;
            r_cnt    <= w_cnt_nxt;
            r_part   <= w_part_nxt;
            r_ovalid <= w_ovalid_nxt;
            for (int i = 0; i < 5; i++) begin
                r_fill[i] <= w_fill_nxt[i];
                r_out[i]  <= w_out_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fc_nxt     = w_fc_acc;
        w_fill_nxt   = r_fill;
        w_out_nxt    = r_out;
        w_cnt_nxt    = r_cnt;
        w_part_nxt   = r_part;
        w_ovalid_nxt = r_ovalid;

        for (int i = 0; i < 5; i++) begin
            if (w_accept && (r_fc == 3'(i))) begin
                w_fill_nxt[i] = bus.IN_DATA;
            end
        end

        if (w_xfer) begin
            // Lanes past the fill count carry stale data from an earlier
            // group, so they are masked to zero on the way out.
            for (int i = 0; i < 5; i++) begin
                w_out_nxt[i] = (3'(i) < w_fc_acc) ? w_fill_nxt[i] : '0;
            end
            w_cnt_nxt    = w_fc_acc;
            w_part_nxt   = !w_full;
            w_ovalid_nxt = 1'b1;
            w_fc_nxt     = 3'd0;
        end else if (bus.OUT_READY) begin
            w_ovalid_nxt = 1'b0;
        end

        // A full group outranks a flush, so FLUSH with the 5th sample or
        // while stalled full stays a normal full group.
        if (w_xfer) begin
            w_state_nxt = S_EMPTY;
        end else if (w_full) begin
            w_state_nxt = S_STALL_FULL;
        end else if (w_flush_close) begin
            w_state_nxt = S_FLUSH_PEND;
        end else if (w_fc_acc == 3'd0) begin
            w_state_nxt = S_EMPTY;
        end else begin
            w_state_nxt = S_FILLING;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.A         = r_out[0];
    assign bus.B         = r_out[1];
    assign bus.C         = r_out[2];
    assign bus.D         = r_out[3];
    assign bus.E         = r_out[4];
    assign bus.GROUP_CNT = r_cnt;
    assign bus.PARTIAL   = r_part;
    assign bus.OUT_VALID = r_ovalid;

endmodule

// File: tb/tb_operand_packer.sv
// tb/tb_operand_packer.sv - self-checking bench for operand_packer against a queue-based group model
module tb_operand_packer;

    localparam int W = 16;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    operand_packer_if #(.WIDTH(W)) bus ();

    operand_packer #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: operands waiting in the fill stage, a flag for a
    // closed-but-not-yet-delivered short group, and the presented group.
    logic [W-1:0] m_fill [$];
    bit           m_closed;
    bit           m_alive;
    bit           m_valid;
    logic [W-1:0] m_lane [5];
    int           m_cnt;
    bit           m_part;

    int           cur_data;
    bit           use_rand;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_ready;
        exp_ready = m_alive && (m_fill.size() < 5) && !m_closed;
        chk("in_ready",  32'(bus.IN_READY),  32'(exp_ready));
        chk("out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
        chk("group_cnt", 32'(bus.GROUP_CNT), 32'(m_cnt));
        chk("partial",   32'(bus.PARTIAL),   32'(m_part));
        chk("lane_a",    32'(bus.A),         32'(m_lane[0]));
        chk("lane_b",    32'(bus.B),         32'(m_lane[1]));
        chk("lane_c",    32'(bus.C),         32'(m_lane[2]));
        chk("lane_d",    32'(bus.D),         32'(m_lane[3]));
        chk("lane_e",    32'(bus.E),         32'(m_lane[4]));
    endtask

    task automatic model_reset();
        m_fill.delete();
        m_closed = 1'b0;
        m_alive  = 1'b0;
        m_valid  = 1'b0;
        m_cnt    = 0;
        m_part   = 1'b0;
        for (int i = 0; i < 5; i++) m_lane[i] = '0;
    endtask

    // What the coming rising edge does, stated as group-forming rules.
    task automatic model_edge(input bit v, input bit f, input bit r);
        bit ready, acc, free, close;
        int n;
        ready = m_alive && (m_fill.size() < 5) && !m_closed;
        acc   = v && ready;
        free  = !m_valid || r;
        if (acc) begin
            m_fill.push_back(bus.IN_DATA);
            cur_data = use_rand ? int'($urandom_range(0, 65535)) : cur_data + 1;
        end
        n     = m_fill.size();
        close = (n == 5) || m_closed || (f && n > 0);
        if (close && free) begin
            for (int i = 0; i < 5; i++) m_lane[i] = (i < n) ? m_fill[i] : '0;
            m_cnt    = n;
            m_part   = (n < 5);
            m_valid  = 1'b1;
            m_fill.delete();
            m_closed = 1'b0;
        end else begin
            if (r) m_valid = 1'b0;
            if (close && n < 5) m_closed = 1'b1;
        end
        m_alive = 1'b1;
    endtask

    task automatic cyc(input bit v, input bit f, input bit r);
        @(negedge CLK);
        bus.IN_VALID  = v;
        bus.IN_DATA   = W'(cur_data);
        bus.FLUSH     = f;
        bus.OUT_READY = r;
        #1;
        check_outputs();
        model_edge(v, f, r);
    endtask

    // Asynchronous reset pulse placed between clock edges, held across one
    // rising edge; outputs must clear at once.
    task automatic reset_pulse();
        @(negedge CLK);
        bus.IN_VALID  = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b1;
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge CLK);
        check_outputs();
        RST_N = 1'b1;
        #1;
        check_outputs();
        model_edge(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.FLUSH     = 1'b0;
        bus.OUT_READY = 1'b1;
        use_rand      = 1'b0;
        cur_data      = 1;
        model_reset();

        reset_pulse();

        // 1..5 with the sink always ready, then idle to see the group.
        cur_data = 1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

        // 1..10 back to back: two groups with no bubble.
        cur_data = 1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);

        // Sink stalled while 11+ samples are offered, then released.
        cur_data = 100;
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, (i != 4));
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1);

        // 7,8,9 then FLUSH.
        cur_data = 7;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // FLUSH with nothing filled is ignored.
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // FLUSH together with the 5th accept: a normal full group.
        cur_data = 40;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Output held with 2 in fill, then FLUSH, a repeat FLUSH, release.
        cur_data = 200;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Reset mid-group with 3 filled, then a fresh group of 5.
        cur_data = 300;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
        reset_pulse();
        cur_data = 400;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);

        // Random traffic.
        use_rand = 1'b1;
        cur_data = int'($urandom_range(0, 65535));
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_packer.md
OPERAND_PACKER -- requirements
Module: operand_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits (matches the adder tree operand width).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port IN_DATA, input, WIDTH bits: serial operand.
REQ-005 SHALL have port IN_VALID, input, 1 bit: IN_DATA is valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: the packer accepts IN_DATA this cycle.
REQ-007 SHALL have port FLUSH, input, 1 bit: close the current partial group.
REQ-008 SHALL have ports A, B, C, D, E, output, WIDTH bits each: packed operand lanes for the downstream five-input ternary adder tree.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: A..E hold a complete group.
REQ-010 SHALL have port OUT_READY, input, 1 bit: the downstream stage takes the group this cycle.
REQ-011 SHALL have port GROUP_CNT, output, 3 bits: number of real operands in the presented group, 1..5.
REQ-012 SHALL have port PARTIAL, output, 1 bit: the presented group was closed by FLUSH with GROUP_CNT<5.

Function
REQ-013 SHALL accept a sample exactly on cycles with IN_VALID=1 and IN_READY=1.
REQ-014 SHALL pack operands in arrival order: 1st->A, 2nd->B, 3rd->C, 4th->D, 5th->E.
REQ-015 SHALL hold a fill register of 5 lanes and a fill count FC (0..5), plus an output register driving A..E, GROUP_CNT, PARTIAL and OUT_VALID.
REQ-016 SHALL treat the output register as free when OUT_VALID=0, or when OUT_VALID=1 and OUT_READY=1 in the same cycle.
REQ-017 SHALL transfer a group on the same edge that accepts the 5th sample if the output register is free, so OUT_VALID rises 1 cycle after the 5th accept, with FC returning to 0.
REQ-018 SHALL, if the output register is not free when the 5th sample arrives, set FC=5, drive IN_READY=0, and transfer on the first edge where the output register is free.
REQ-019 SHALL sustain one group per 5 accepted samples with no bubble when OUT_READY is held at 1.
REQ-020 SHALL keep A..E, GROUP_CNT and PARTIAL stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 SHALL clear OUT_VALID after a handshake unless a new group transfers on the same edge.
REQ-022 SHALL drive IN_READY=1 iff FC<5 and no flush is pending.
REQ-023 SHALL, on FLUSH=1 with FC>0 (counting a sample accepted in the same cycle), close the group: unfilled lanes=0, GROUP_CNT=FC, PARTIAL=(FC<5).
REQ-024 SHALL, if the output register is not free at flush, set a pending-flush flag and transfer when it becomes free; FLUSH pulses while the flag is set SHALL be ignored.
REQ-025 SHALL ignore FLUSH when FC=0 and no sample is accepted that cycle.
REQ-026 SHALL treat FLUSH coinciding with the 5th accept as a normal full group (GROUP_CNT=5, PARTIAL=0).
REQ-027 SHALL implement the control states EMPTY (FC=0), FILLING (1..4), STALL_FULL (FC=5, waiting), and FLUSH_PEND (flag set, waiting), with the transitions given in REQ-017 to REQ-026.
REQ-028 SHALL never drop or duplicate a sample, and SHALL never present a group with GROUP_CNT=0.

Reset
REQ-029 SHALL, while RST_N=0, asynchronously force FC=0, clear the pending-flush flag, and force A..E=0, GROUP_CNT=0, PARTIAL=0, OUT_VALID=0 and IN_READY=0.
REQ-030 SHALL drive IN_READY=1 from the first rising CLK edge after RST_N deasserts.
REQ-031 SHALL discard any partial group or held output when reset is asserted mid-operation.

Verification
REQ-032 SHALL be verified by streaming 1,2,3,4,5 with OUT_READY=1 -> 1 cycle after the 5th accept: A..E=1,2,3,4,5, GROUP_CNT=5, PARTIAL=0, OUT_VALID=1 for 1 cycle.
REQ-033 SHALL be verified by streaming 10 back-to-back samples 1..10 with OUT_READY=1 -> groups {1..5} and {6..10} on consecutive 5-cycle slots, and IN_READY never drops.
REQ-034 SHALL be verified by holding OUT_READY=0 and sending 11 samples -> the first group is held stable, FC reaches 5, IN_READY=0, and the 11th sample is not accepted until OUT_READY=1.
REQ-035 SHALL be verified by sending 7,8,9 then FLUSH -> A..E=7,8,9,0,0, GROUP_CNT=3, PARTIAL=1.
REQ-036 SHALL be verified by sending FLUSH while the output is held with 2 samples in fill -> FLUSH_PEND, IN_READY=0, and a partial group with GROUP_CNT=2 issues after OUT_READY=1.
REQ-037 SHALL be verified by pulsing RST_N=0 asynchronously mid-group (3 samples filled) -> all outputs 0 immediately, and the next 5 samples form a fresh group starting at A.
